// File: rtl/apb_master_bridge.sv
// CPU data bus to APB master bridge: address decode to one PSEL, IDLE/SETUP/ACCESS sequencing.
// Optional ACCESS wait timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int          NUM_SLV        = 4,
   parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic                   PCLK,
   input  logic                   PRESET,
   input  logic                   transfer,
   input  logic                   write,
   input  logic [31:0]            addr,
   input  logic [31:0]            wdata,
   output logic [31:0]            rdata,
   output logic                   ready,
   output logic                   err,
   output logic [31:0]            PADDR,
   output logic                   PWRITE,
   output logic [31:0]            PWDATA,
   output logic                   PENABLE,
   output logic [NUM_SLV-1:0]     PSEL,
   input  logic [32*NUM_SLV-1:0]  PRDATA,
   input  logic [NUM_SLV-1:0]     PREADY
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t               state;
   logic                 hit;
   logic [3:0]           idx;
   logic                 dec_hit;
   logic [NUM_SLV-1:0]   dec_sel;
   logic                 sel_ready;
   logic [31:0]          sel_rdata;
`ifdef APB_TIMEOUT_EN
   logic [7:0]           wait_cnt;
`endif

   always_comb begin
      dec_hit = (addr[31:16] == BASE_ADDR[31:16]) && (int'(addr[15:12]) < NUM_SLV);
      dec_sel = '0;
      for (int i = 0; i < NUM_SLV; i++)
         if (dec_hit && int'(addr[15:12]) == i) dec_sel[i] = 1'b1;
   end

   // Loop mux keeps the slave index in range even when NUM_SLV < 16.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++)
         if (int'(idx) == i) begin
            sel_ready = PREADY[i];
            sel_rdata = PRDATA[32*i +: 32];
         end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state    <= IDLE;
         hit      <= 1'b0;
         idx      <= '0;
         PSEL     <= '0;
         PENABLE  <= 1'b0;
         PWRITE   <= 1'b0;
         PADDR    <= '0;
         PWDATA   <= '0;
         ready    <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
`ifdef APB_TIMEOUT_EN
         wait_cnt <= '0;
`endif
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: if (transfer) begin
               PADDR  <= addr;
               PWRITE <= write;
               PWDATA <= wdata;
               hit    <= dec_hit;
               idx    <= addr[15:12];
               PSEL   <= dec_sel;
               state  <= SETUP;
            end
            SETUP: begin
               PENABLE  <= 1'b1;
               state    <= ACCESS;
`ifdef APB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ACCESS: begin
               if (!hit) begin
                  rdata   <= '0;
                  err     <= 1'b1;
                  ready   <= 1'b1;
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  state   <= IDLE;
               end else if (sel_ready) begin
                  rdata   <= PWRITE ? 32'd0 : sel_rdata;
                  err     <= 1'b0;
                  ready   <= 1'b1;
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  state   <= IDLE;
               end
`ifdef APB_TIMEOUT_EN
               // PREADY in the final allowed cycle takes priority over the abort.
               else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                  rdata   <= '0;
                  err     <= 1'b1;
                  ready   <= 1'b1;
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed cases plus randomized transfers
// compared against a transaction-level expectation (select, latency, data, error).
module tb_apb_master_bridge;
   localparam int NUM_SLV = 4;
   localparam int TMO     = 16;

   logic                  PCLK = 1'b0;
   logic                  PRESET;
   logic                  transfer, write;
   logic [31:0]           addr, wdata;
   logic [31:0]           rdata;
   logic                  ready, err;
   logic [31:0]           PADDR, PWDATA;
   logic                  PWRITE, PENABLE;
   logic [NUM_SLV-1:0]    PSEL;
   logic [32*NUM_SLV-1:0] PRDATA;
   logic [NUM_SLV-1:0]    PREADY;

   int errors = 0;
   int checks = 0;

   apb_master_bridge #(.NUM_SLV(NUM_SLV), .BASE_ADDR(32'h1000_0000), .TIMEOUT_CYCLES(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write), .addr(addr),
      .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .PADDR(PADDR), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Random bus noise; the selected slave (sel >= 0) gets a controlled PREADY and data.
   task automatic drive_bus(input int sel, input logic rdy, input logic [31:0] rd);
      PREADY = NUM_SLV'($urandom);
      for (int i = 0; i < NUM_SLV; i++) PRDATA[32*i +: 32] = $urandom;
      if (sel >= 0) begin
         PREADY[sel]          = rdy;
         PRDATA[32*sel +: 32] = rd;
      end
   endtask

   // One CPU transfer. waits = ACCESS cycles before the slave raises PREADY.
   // chain=1 leaves transfer high at completion so the caller's next transfer is back-to-back.
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input int waits, input logic [31:0] rd, input bit chain);
      logic        exp_hit;
      int          sidx, exp_lat, cyc;
      logic [31:0] exp_psel, exp_rd;
      logic        exp_err, rdy;
      bit          done;
      exp_hit  = (a[31:16] == 16'h1000) && (int'(a[15:12]) < NUM_SLV);
      sidx     = exp_hit ? int'(a[15:12]) : -1;
      exp_psel = exp_hit ? (32'd1 << sidx) : 32'd0;
      exp_lat  = exp_hit ? 3 + waits : 3;
      exp_rd   = (exp_hit && !wr) ? rd : 32'd0;
      exp_err  = !exp_hit;
      @(negedge PCLK);
      transfer = 1'b1; write = wr; addr = a; wdata = wd;
      drive_bus(sidx, 1'($urandom), rd);
      done = 0; cyc = 0;
      while (!done && cyc < 60) begin
         @(posedge PCLK); #1; cyc++;
         if (ready) begin
            chk("latency", 32'(cyc), 32'(exp_lat));
            chk("rdata", rdata, exp_rd);
            chk("err", 32'(err), 32'(exp_err));
            done = 1;
            if (!chain) transfer = 1'b0;
         end else begin
            chk("psel", 32'(PSEL), exp_psel);
            chk("penable", 32'(PENABLE), 32'(cyc >= 2));
            chk("paddr", PADDR, a);
            if (cyc == 1) begin
               chk("pwrite", 32'(PWRITE), 32'(wr));
               chk("pwdata", PWDATA, wd);
            end
         end
         if (done || cyc < 2) rdy = 1'($urandom);
         else                 rdy = exp_hit && (cyc >= 2 + waits);
         drive_bus(sidx, rdy, rd);
      end
      chk("completed", 32'(done), 32'd1);
      if (!done) begin
         @(negedge PCLK); PRESET = 1'b1; transfer = 1'b0;
         @(negedge PCLK); PRESET = 1'b0;
      end else if (!chain) begin
         @(posedge PCLK); #1;
         chk("ready_pulse", 32'(ready), 32'd0);
         chk("rdata_hold", rdata, exp_rd);
      end
   endtask

   initial begin
      int          cyc;
      bit          seen;
      logic [3:0]  s4;
      logic [31:0] a;
      PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
      PRDATA = '0; PREADY = '0;
      repeat (2) @(posedge PCLK);
      #1;
      chk("rst_psel", 32'(PSEL), 32'd0);
      chk("rst_penable", 32'(PENABLE), 32'd0);
      chk("rst_paddr", PADDR, 32'd0);
      chk("rst_pwdata", PWDATA, 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(negedge PCLK); PRESET = 1'b0;

      xfer(1'b1, 32'h1000_0000, 32'h0000_00FF, 1, 32'h0, 0);
      xfer(1'b0, 32'h1000_1008, 32'h0, 0, 32'h0000_005A, 0);
      xfer(1'b0, 32'h2000_0000, 32'h0, 0, 32'hDEAD_BEEF, 0);
      xfer(1'b0, 32'h1000_4000, 32'h0, 0, 32'h1234_5678, 0);
      xfer(1'b1, 32'h1000_3004, 32'hCAFE_0001, 2, 32'h0, 1);
      xfer(1'b0, 32'h1000_2010, 32'h0, 0, 32'hA5A5_0002, 0);
      repeat (3) begin
         @(posedge PCLK); #1;
         chk("no_dup", 32'(ready), 32'd0);
      end
      xfer(1'b0, 32'h1000_2000, 32'h0, TMO - 1, 32'h0BAD_F00D, 0);

      // Reset while in ACCESS: bus idles next edge, no completion pulse afterwards.
      @(negedge PCLK);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_3000;
      for (int i = 0; i < 4; i++) begin
         drive_bus(3, 1'b0, 32'h1);
         @(negedge PCLK);
      end
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      chk("mrst_psel", 32'(PSEL), 32'd0);
      chk("mrst_penable", 32'(PENABLE), 32'd0);
      chk("mrst_ready", 32'(ready), 32'd0);
      chk("mrst_paddr", PADDR, 32'd0);
      @(negedge PCLK); PRESET = 1'b0; transfer = 1'b0;
      seen = 0;
      repeat (4) begin
         @(posedge PCLK); #1;
         if (ready) seen = 1;
      end
      chk("mrst_no_pulse", 32'(seen), 32'd0);
      xfer(1'b0, 32'h1000_1000, 32'h0, 1, 32'h7777_0003, 0);

      // Slave 2 never responds.
      @(negedge PCLK);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_2000;
      drive_bus(2, 1'b0, 32'h5);
`ifdef APB_TIMEOUT_EN
      cyc = 0; seen = 0;
      while (!seen && cyc < 60) begin
         @(posedge PCLK); #1; cyc++;
         if (ready) seen = 1;
         drive_bus(2, 1'b0, 32'h5);
      end
      transfer = 1'b0;
      chk("tmo_seen", 32'(seen), 32'd1);
      chk("tmo_latency", 32'(cyc), 32'(TMO + 2));
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_rdata", rdata, 32'd0);
`else
      cyc = 0; seen = 0;
      repeat (100) begin
         @(posedge PCLK); #1; cyc++;
         if (ready) seen = 1;
         drive_bus(2, 1'b0, 32'h5);
      end
      chk("hang_no_ready", 32'(seen), 32'd0);
      chk("hang_penable", 32'(PENABLE), 32'd1);
      @(negedge PCLK); PRESET = 1'b1; transfer = 1'b0;
      @(negedge PCLK); PRESET = 1'b0;
`endif

      for (int n = 0; n < 24; n++) begin
         s4 = 4'($urandom_range(0, 5));
         if (n % 5 == 4) a = 32'h3000_0000 | 32'($urandom_range(0, 32'hFFFF));
         else            a = {16'h1000, s4, 12'($urandom)};
         xfer(1'($urandom), a, $urandom, int'($urandom_range(0, 4)), $urandom,
              (n < 23) && ($urandom_range(0, 1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
